// File: rtl/dcache_arb_pkg.sv
// Shared definitions for the dcache request arbiter: ID/tag widths, arbiter
// state encoding and the tag pack/unpack helpers.
package dcache_arb_pkg;

  localparam int TAG_MAX_W = 64;
  typedef logic [TAG_MAX_W-1:0] tag_max_t;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int id_w(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int tag_out_w(input int tag_in_w, input int num_reqs);
    return tag_in_w + id_w(num_reqs);
  endfunction

  // Requester ID sits in the LSBs of the outgoing tag.
  function automatic tag_max_t tag_pack(input tag_max_t tag_in, input tag_max_t id, input int idw);
    return (tag_in << idw) | id;
  endfunction

  function automatic tag_max_t tag_strip(input tag_max_t tag_out, input int idw);
    return tag_out >> idw;
  endfunction

  function automatic tag_max_t tag_id(input tag_max_t tag_out, input int idw);
    return tag_out & ((tag_max_t'(1) << idw) - tag_max_t'(1));
  endfunction

endpackage

// File: rtl/dcache_req_arbiter_rr.sv
// Round-robin priority picker with lock: while locked the owner wins outright,
// otherwise the first requester at or above the pointer (with wrap) wins.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   i_req,
  input  logic           i_lock,
  input  logic [IDW-1:0] i_owner,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_idx
);

  logic           w_found;
  logic [IDW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = i_owner;
    w_found = i_lock;
    w_cand  = '0;
    if (!i_lock) begin
      o_idx = '0;
      for (int k = 0; k < N; k++) begin
        w_cand = IDW'((int'(i_ptr) + k) % N);
        if (!w_found && i_req[w_cand]) begin
          w_found = 1'b1;
          o_idx   = w_cand;
        end
      end
    end
    for (int r = 0; r < N; r++)
      o_grant[r] = w_found && (o_idx == IDW'(r));
  end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Shares one lane-parallel dcache port among NUM_REQS requesters: locked
// round-robin request arbitration plus a one-entry registered response stage.
module dcache_req_arbiter import dcache_arb_pkg::*; #(
  parameter  int NUM_REQS  = 2,
  parameter  int NUM_LANES = 4,
  parameter  int ADDR_W    = 30,
  parameter  int DATA_W    = 32,
  parameter  int TAG_IN_W  = 16,
  localparam int ID_W      = id_w(NUM_REQS),
  localparam int TAG_OUT_W = tag_out_w(TAG_IN_W, NUM_REQS)
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0]                  i_req_valid,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0]                  i_req_rw,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][ADDR_W-1:0]      i_req_addr,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][DATA_W/8-1:0]    i_req_byteen,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][DATA_W-1:0]      i_req_data,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][TAG_IN_W-1:0]    i_req_tag,
  output logic [NUM_REQS-1:0][NUM_LANES-1:0]                  o_req_ready,
  output logic [NUM_LANES-1:0]                                o_mem_req_valid,
  output logic [NUM_LANES-1:0]                                o_mem_req_rw,
  output logic [NUM_LANES-1:0][ADDR_W-1:0]                    o_mem_req_addr,
  output logic [NUM_LANES-1:0][DATA_W/8-1:0]                  o_mem_req_byteen,
  output logic [NUM_LANES-1:0][DATA_W-1:0]                    o_mem_req_data,
  output logic [NUM_LANES-1:0][TAG_OUT_W-1:0]                 o_mem_req_tag,
  input  logic [NUM_LANES-1:0]                                i_mem_req_ready,
  input  logic                                                i_mem_rsp_valid,
  input  logic [NUM_LANES-1:0]                                i_mem_rsp_tmask,
  input  logic [NUM_LANES-1:0][DATA_W-1:0]                    i_mem_rsp_data,
  input  logic [TAG_OUT_W-1:0]                                i_mem_rsp_tag,
  output logic                                                o_mem_rsp_ready,
  output logic [NUM_REQS-1:0]                                 o_rsp_valid,
  output logic [NUM_LANES-1:0]                                o_rsp_tmask,
  output logic [NUM_LANES-1:0][DATA_W-1:0]                    o_rsp_data,
  output logic [TAG_IN_W-1:0]                                 o_rsp_tag,
  input  logic [NUM_REQS-1:0]                                 i_rsp_ready,
  output logic [31:0]                                         o_perf_stalls
);

  arb_state_e               r_state, w_state_nxt;
  logic [ID_W-1:0]          r_owner, w_owner_nxt;
  logic [ID_W-1:0]          r_ptr, w_ptr_nxt;
  logic [31:0]              r_perf_stalls;
  logic [NUM_REQS-1:0]      w_req_any;
  logic [NUM_REQS-1:0]      w_grant;
  logic [ID_W-1:0]          w_sel;
  logic [NUM_LANES-1:0]     w_sel_valid;
  logic                     w_any;
  logic                     w_done;
  logic                     w_stall;

  for (genvar r = 0; r < NUM_REQS; r++) begin : g_req
    assign w_req_any[r]   = |i_req_valid[r];
    assign o_req_ready[r] = w_grant[r] ? i_mem_req_ready : '0;
  end

  rr_arbiter #(.N(NUM_REQS), .IDW(ID_W)) u_rr (
    .i_req   (w_req_any),
    .i_lock  (r_state == ARB_LOCKED),
    .i_owner (r_owner),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_sel)
  );

  assign w_sel_valid      = i_req_valid[w_sel];
  assign w_any            = |w_sel_valid;
  assign w_done           = w_any && ((w_sel_valid & ~i_mem_req_ready) == '0);
  assign o_mem_req_valid  = w_sel_valid;
  assign o_mem_req_rw     = i_req_rw[w_sel];
  assign o_mem_req_addr   = i_req_addr[w_sel];
  assign o_mem_req_byteen = i_req_byteen[w_sel];
  assign o_mem_req_data   = i_req_data[w_sel];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_tag
    assign o_mem_req_tag[l] = TAG_OUT_W'(tag_pack(tag_max_t'(i_req_tag[w_sel][l]),
                                                  tag_max_t'(w_sel), ID_W));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_FREE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // An owner that drops all its lanes releases the lock without moving the pointer.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    if (w_any) begin
      if (w_done) begin
        w_state_nxt = ARB_FREE;
        w_ptr_nxt   = (w_sel == ID_W'(NUM_REQS - 1)) ? '0 : w_sel + ID_W'(1);
      end else begin
        w_state_nxt = ARB_LOCKED;
        w_owner_nxt = w_sel;
      end
    end else if (r_state == ARB_LOCKED) begin
      w_state_nxt = ARB_FREE;
    end
  end

  assign w_stall = |(w_req_any & ~w_grant);

  always_ff @(posedge clk) begin
    if (reset)        r_perf_stalls <= '0;
    else if (w_stall) r_perf_stalls <= r_perf_stalls + 32'd1;
  end

  assign o_perf_stalls = r_perf_stalls;

  logic                            r_rsp_valid;
  logic [NUM_LANES-1:0]            r_rsp_tmask;
  logic [NUM_LANES-1:0][DATA_W-1:0] r_rsp_data;
  logic [TAG_OUT_W-1:0]            r_rsp_tag;
  logic [ID_W-1:0]                 w_rsp_id;
  logic                            w_rsp_ready;

  assign w_rsp_id    = ID_W'(tag_id(tag_max_t'(r_rsp_tag), ID_W));
  // Only the addressed requester's ready can hold the register.
  assign w_rsp_ready = ~(r_rsp_valid & ~i_rsp_ready[w_rsp_id]);

  always_ff @(posedge clk) begin
    if (reset)            r_rsp_valid <= 1'b0;
    else if (w_rsp_ready) r_rsp_valid <= i_mem_rsp_valid;
  end

  always_ff @(posedge clk) begin
    if (w_rsp_ready && i_mem_rsp_valid) begin
      r_rsp_tmask <= i_mem_rsp_tmask;
      r_rsp_data  <= i_mem_rsp_data;
      r_rsp_tag   <= i_mem_rsp_tag;
    end
  end

  for (genvar r = 0; r < NUM_REQS; r++) begin : g_rsp
    assign o_rsp_valid[r] = r_rsp_valid && (w_rsp_id == ID_W'(r));
  end

  assign o_mem_rsp_ready = w_rsp_ready;
  assign o_rsp_tmask     = r_rsp_tmask;
  assign o_rsp_data      = r_rsp_data;
  assign o_rsp_tag       = TAG_IN_W'(tag_strip(tag_max_t'(r_rsp_tag), ID_W));

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Scoreboard bench for dcache_req_arbiter: directed scenarios plus random
// traffic checked against a behavioural arbitration/response model.
module tb_dcache_req_arbiter;

  localparam int NR = 2, NL = 4, AW = 30, DW = 32, TW = 16, IDW = 1, TOW = 17, BW = DW/8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0][NL-1:0]         i_req_valid = '0, i_req_rw = '0;
  logic [NR-1:0][NL-1:0][AW-1:0] i_req_addr = '0;
  logic [NR-1:0][NL-1:0][BW-1:0] i_req_byteen = '0;
  logic [NR-1:0][NL-1:0][DW-1:0] i_req_data = '0;
  logic [NR-1:0][NL-1:0][TW-1:0] i_req_tag = '0;
  logic [NR-1:0][NL-1:0]         o_req_ready;
  logic [NL-1:0]                 o_mem_req_valid, o_mem_req_rw;
  logic [NL-1:0][AW-1:0]         o_mem_req_addr;
  logic [NL-1:0][BW-1:0]         o_mem_req_byteen;
  logic [NL-1:0][DW-1:0]         o_mem_req_data;
  logic [NL-1:0][TOW-1:0]        o_mem_req_tag;
  logic [NL-1:0]                 i_mem_req_ready = '1;
  logic                          i_mem_rsp_valid = 1'b0;
  logic [NL-1:0]                 i_mem_rsp_tmask = '0;
  logic [NL-1:0][DW-1:0]         i_mem_rsp_data = '0;
  logic [TOW-1:0]                i_mem_rsp_tag = '0;
  logic                          o_mem_rsp_ready;
  logic [NR-1:0]                 o_rsp_valid;
  logic [NL-1:0]                 o_rsp_tmask;
  logic [NL-1:0][DW-1:0]         o_rsp_data;
  logic [TW-1:0]                 o_rsp_tag;
  logic [NR-1:0]                 i_rsp_ready = '1;
  logic [31:0]                   o_perf_stalls;

  always #5 clk = ~clk;

  dcache_req_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_rw(i_req_rw), .i_req_addr(i_req_addr),
    .i_req_byteen(i_req_byteen), .i_req_data(i_req_data), .i_req_tag(i_req_tag),
    .o_req_ready(o_req_ready),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_rw(o_mem_req_rw),
    .o_mem_req_addr(o_mem_req_addr), .o_mem_req_byteen(o_mem_req_byteen),
    .o_mem_req_data(o_mem_req_data), .o_mem_req_tag(o_mem_req_tag),
    .i_mem_req_ready(i_mem_req_ready),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_tmask(i_mem_rsp_tmask),
    .i_mem_rsp_data(i_mem_rsp_data), .i_mem_rsp_tag(i_mem_rsp_tag),
    .o_mem_rsp_ready(o_mem_rsp_ready),
    .o_rsp_valid(o_rsp_valid), .o_rsp_tmask(o_rsp_tmask), .o_rsp_data(o_rsp_data),
    .o_rsp_tag(o_rsp_tag), .i_rsp_ready(i_rsp_ready),
    .o_perf_stalls(o_perf_stalls)
  );

  int n_pass = 0, n_chk = 0;
  bit in_reset = 1'b1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [NL-1:0]         vld, rw;
    logic [NL-1:0][AW-1:0] addr;
    logic [NL-1:0][BW-1:0] be;
    logic [NL-1:0][DW-1:0] data;
    logic [NL-1:0][TOW-1:0] tag;
    logic [NR-1:0][NL-1:0] rdy;
  } req_exp_t;

  typedef struct {
    int                    id;
    logic [TW-1:0]         tag;
    logic [NL-1:0]         tmask;
    logic [NL-1:0][DW-1:0] data;
  } rsp_exp_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];

  // Requester-side state and the reference arbitration model.
  logic [NL-1:0] pend [NR];
  bit            m_locked = 1'b0;
  int            m_owner = 0, m_ptr = 0;
  logic [31:0]   m_stalls = '0;

  task automatic new_req(input int r, input logic [NL-1:0] mask, input logic [TW-1:0] tag0);
    pend[r] = mask;
    for (int l = 0; l < NL; l++) begin
      i_req_rw[r][l]     = 1'($urandom);
      i_req_addr[r][l]   = AW'($urandom);
      i_req_byteen[r][l] = BW'($urandom);
      i_req_data[r][l]   = $urandom;
      i_req_tag[r][l]    = tag0 + TW'(l);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply the requesters' lanes for this cycle and predict what the port carries.
  task automatic step();
    int s;
    bit found, st;
    req_exp_t e;
    logic [NL-1:0] left;
    chk("perf_stalls", o_perf_stalls, m_stalls);
    for (int r = 0; r < NR; r++) i_req_valid[r] = pend[r];
    found = m_locked;
    s = m_locked ? m_owner : 0;
    if (!m_locked)
      for (int k = 0; k < NR; k++)
        if (!found && pend[(m_ptr + k) % NR] != 0) begin
          found = 1'b1;
          s = (m_ptr + k) % NR;
        end
    st = 1'b0;
    for (int r = 0; r < NR; r++) if (r != s && pend[r] != 0) st = 1'b1;
    if (st) m_stalls = m_stalls + 1;
    if (found && pend[s] != 0) begin
      e.vld = pend[s]; e.rw = i_req_rw[s]; e.addr = i_req_addr[s];
      e.be = i_req_byteen[s]; e.data = i_req_data[s];
      for (int l = 0; l < NL; l++) e.tag[l] = {i_req_tag[s][l], IDW'(s)};
      e.rdy = '0;
      e.rdy[s] = i_mem_req_ready;
      req_q.push_back(e);
      left = pend[s] & ~i_mem_req_ready;
      pend[s] = left;
      if (left == 0) begin m_locked = 1'b0; m_ptr = (s + 1) % NR; end
      else begin m_locked = 1'b1; m_owner = s; end
    end else begin
      m_locked = 1'b0;
    end
  endtask

  task automatic set_rsp(input logic v, input logic [TOW-1:0] tag, input logic [NL-1:0] tmask);
    i_mem_rsp_valid = v;
    i_mem_rsp_tag   = tag;
    i_mem_rsp_tmask = tmask;
    for (int l = 0; l < NL; l++) i_mem_rsp_data[l] = $urandom;
  endtask

  task automatic enter_reset();
    reset = 1'b1; in_reset = 1'b1;
    i_req_valid = '0; i_mem_rsp_valid = 1'b0;
    for (int r = 0; r < NR; r++) pend[r] = '0;
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_stalls = '0;
    req_q.delete(); rsp_q.delete();
  endtask

  // Monitor: pops expectations whenever the DUT presents traffic.
  always @(negedge clk) begin : mon
    req_exp_t e;
    rsp_exp_t h;
    bit has;
    logic [NR-1:0] ev;
    if (!in_reset) begin
      if (o_mem_req_valid != 0) begin
        if (req_q.size() == 0) chk("req_unexpected", o_mem_req_valid, 0);
        else begin
          e = req_q.pop_front();
          chk("mem_req_valid", o_mem_req_valid, e.vld);
          chk("mem_req_rw", o_mem_req_rw, e.rw);
          chk("mem_req_addr", o_mem_req_addr, e.addr);
          chk("mem_req_byteen", o_mem_req_byteen, e.be);
          chk("mem_req_data", o_mem_req_data, e.data);
          chk("mem_req_tag", o_mem_req_tag, e.tag);
          chk("req_ready", o_req_ready, e.rdy);
        end
      end
      has = rsp_q.size() > 0;
      ev = '0;
      h.id = 0;
      if (has) begin h = rsp_q[0]; ev[h.id] = 1'b1; end
      chk("rsp_valid", o_rsp_valid, ev);
      chk("mem_rsp_ready", o_mem_rsp_ready, !(has && !i_rsp_ready[h.id]));
      if (has && i_rsp_ready[h.id]) begin
        chk("rsp_tag", o_rsp_tag, h.tag);
        chk("rsp_tmask", o_rsp_tmask, h.tmask);
        chk("rsp_data", o_rsp_data, h.data);
        void'(rsp_q.pop_front());
      end
      if (i_mem_rsp_valid && o_mem_rsp_ready) begin
        h.id    = int'(i_mem_rsp_tag[IDW-1:0]);
        h.tag   = i_mem_rsp_tag[TOW-1:IDW];
        h.tmask = i_mem_rsp_tmask;
        h.data  = i_mem_rsp_data;
        rsp_q.push_back(h);
      end
    end
  end

  initial begin
    for (int r = 0; r < NR; r++) pend[r] = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; in_reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_req_valid", o_mem_req_valid, 0);
    chk("rst_req_ready", o_req_ready, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_perf", o_perf_stalls, 0);
    chk("rst_mem_rsp_ready", o_mem_rsp_ready, 1);

    // Single requester, all lanes accepted in one cycle.
    cyc(); new_req(0, 4'hf, 16'h0012); i_mem_req_ready = 4'hf; step();
    #1 chk("tag_lane0", o_mem_req_tag[0], 17'h00024);

    // Both continuously valid: grants alternate, one stall per cycle.
    for (int c = 0; c < 5; c++) begin
      cyc();
      for (int r = 0; r < NR; r++) if (pend[r] == 0) new_req(r, 4'hf, TW'($urandom));
      step();
    end

    // Partial acceptance locks requester 0 for two cycles.
    cyc(); new_req(0, 4'hf, 16'h0100); if (pend[1] == 0) new_req(1, 4'hf, 16'h0200);
    i_mem_req_ready = 4'b0011; step();
    cyc(); i_mem_req_ready = 4'b1100; step();
    cyc(); i_mem_req_ready = 4'b1111; step();

    // Response routed to requester 1 with its ID stripped.
    cyc(); set_rsp(1'b1, {16'h0034, 1'b1}, 4'b0101); i_rsp_ready = 2'b11; step();
    cyc(); set_rsp(1'b0, '0, '0); step();
    cyc(); step();

    // Addressed requester stalls for three cycles while another response waits.
    cyc(); set_rsp(1'b1, {16'h0055, 1'b1}, 4'b1010); step();
    for (int c = 0; c < 3; c++) begin
      cyc(); set_rsp(1'b1, {16'h0066, 1'b0}, 4'b1111); i_rsp_ready = 2'b01; step();
    end
    cyc(); i_rsp_ready = 2'b11; step();
    cyc(); set_rsp(1'b0, '0, '0); step();
    cyc(); step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      for (int r = 0; r < NR; r++)
        if (pend[r] == 0 && $urandom_range(0, 2) == 0)
          new_req(r, NL'($urandom_range(1, 15)), TW'($urandom));
      if (m_locked && $urandom_range(0, 15) == 0) pend[m_owner] = '0;
      i_mem_req_ready = ($urandom_range(0, 1) == 1) ? NL'(4'hf) : NL'($urandom);
      set_rsp(1'($urandom_range(0, 1)), TOW'($urandom), NL'($urandom));
      for (int r = 0; r < NR; r++) i_rsp_ready[r] = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain.
    for (int c = 0; c < 6; c++) begin
      cyc();
      for (int r = 0; r < NR; r++) pend[r] = '0;
      i_mem_req_ready = '1; set_rsp(1'b0, '0, '0); i_rsp_ready = '1;
      step();
    end
    @(negedge clk); #1;
    chk("req_q_empty", req_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);

    // Reset while requester 1 holds a lock.
    cyc(); new_req(0, 4'hf, 16'h0300); i_mem_req_ready = 4'hf; step();
    cyc(); new_req(1, 4'hf, 16'h0400); i_mem_req_ready = 4'b0001; step();
    cyc(); enter_reset();
    @(posedge clk); #1 reset = 1'b0; in_reset = 1'b0;
    cyc(); new_req(0, 4'hf, 16'h0500); new_req(1, 4'hf, 16'h0600); i_mem_req_ready = 4'hf; step();
    #1 chk("rst_grant", o_req_ready, 8'h0f);
    cyc(); step();
    @(negedge clk); #1;
    chk("final_req_q_empty", req_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
